// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and
// counting-direction constants.
package count_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit synchronous up/down counter with a parallel load; load has
// priority over enable. Arithmetic wraps modulo 2^WIDTH.
module count_core
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (up_dn == DIR_DOWN) begin
                count <= count - ONE;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Sequencer for the count_core datapath: start/stop/pause control, prescaler,
// latched configuration, terminal compare, one-shot or auto-reload.
//
// state | meaning
// IDLE  | waiting for start, count held at 0
// RUN   | prescaler running, count steps on each prescaler tick
// PAUSE | count and prescaler frozen while pause is high
// DONE  | one-shot finished, count holds terminal value, done=1
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             reload,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [PRE_W-1:0]   presc;
    logic [PRE_W-1:0]   div_l;
    logic [WIDTH-1:0]   limit_l;
    logic               dir_l;
    logic               reload_l;
    logic               start_go;
    logic               tick;
    logic               at_term;
    logic [WIDTH-1:0]   start_val_l;
    logic               core_en;
    logic               core_up_dn;
    logic               core_load;
    logic [WIDTH-1:0]   core_load_val;

    // start is only honoured from IDLE/DONE, and stop always beats it
    assign start_go    = start && !stop && (state == ST_IDLE || state == ST_DONE);
    assign tick        = (state == ST_RUN) && !stop && !pause && (presc == div_l);
    assign at_term     = (dir_l == DIR_DOWN) ? (count == '0) : (count == limit_l);
    assign start_val_l = (dir_l == DIR_DOWN) ? limit_l : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_go) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop)                                 state_nxt = ST_IDLE;
                else if (pause)                           state_nxt = ST_PAUSE;
                else if (tick && at_term && !reload_l)    state_nxt = ST_DONE;
            end
            ST_PAUSE: begin
                if (stop)        state_nxt = ST_IDLE;
                else if (!pause) state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (stop)          state_nxt = ST_IDLE;
                else if (start_go) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            div_l    <= '0;
            limit_l  <= '0;
            dir_l    <= 1'b0;
            reload_l <= 1'b0;
            tc       <= 1'b0;
        end else begin
            tc <= tick && at_term;
            if (stop || start_go) begin
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else if (state == ST_RUN && !pause) begin
                presc <= presc + PRE_ONE;
            end
            if (start_go) begin
                div_l    <= div;
                limit_l  <= limit;
                dir_l    <= dir;
                reload_l <= reload;
            end
        end
    end

    always_comb begin
        busy          = (state == ST_RUN) || (state == ST_PAUSE);
        done          = (state == ST_DONE);
        core_en       = 1'b0;
        core_up_dn    = dir_l;
        core_load     = 1'b0;
        core_load_val = '0;
        if (stop) begin
            core_load     = 1'b1;
        end else if (start_go) begin
            core_load     = 1'b1;
            core_load_val = (dir == DIR_DOWN) ? limit : '0;
        end else if (tick) begin
            if (at_term) begin
                // one-shot leaves the terminal value in place
                core_load     = reload_l;
                core_load_val = start_val_l;
            end else begin
                core_en = 1'b1;
            end
        end
    end

    count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (core_en),
        .up_dn    (core_up_dn),
        .load     (core_load),
        .load_val (core_load_val),
        .count    (count)
    );

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: expected values are hand-derived
// cycle-by-cycle timelines.
module tb_count_sequencer;

    localparam int WIDTH = 4;
    localparam int PRE_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic             reload;
    logic [WIDTH-1:0] limit;
    logic [PRE_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    // down-reload timeline, values after edges 1..12 following start
    int dn_cnt [12] = '{2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};
    int dn_tc  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

    count_sequencer #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .dir    (dir),
        .reload (reload),
        .limit  (limit),
        .div    (div),
        .count  (count),
        .busy   (busy),
        .tc     (tc),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int c, input int b, input int t, input int d);
        check({tag, ".count"}, 32'(count), c);
        check({tag, ".busy"},  32'(busy),  b);
        check({tag, ".tc"},    32'(tc),    t);
        check({tag, ".done"},  32'(done),  d);
    endtask

    // pulse start for one edge, then scramble config to show it was latched
    task automatic start_seq(input logic d, input logic r, input int lim, input int dv);
        dir    = d;
        reload = r;
        limit  = WIDTH'(lim);
        div    = PRE_W'(dv);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        dir    = ~d;
        reload = ~r;
        limit  = 4'hF;
        div    = 8'h07;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        dir = 1'b0; reload = 1'b0; limit = '0; div = '0;
        cyc();
        cyc();
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        check_all("idle", 0, 0, 0, 0);

        // up one-shot, limit=3, div=0
        start_seq(1'b0, 1'b0, 3, 0);
        check_all("up.e0", 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check_all($sformatf("up.e%0d", k), k, 1, 0, 0);
        end
        cyc();
        check_all("up.term", 3, 0, 1, 1);
        cyc();
        check_all("up.hold", 3, 0, 0, 1);

        // restart from DONE: down, auto-reload, limit=2, div=1
        start_seq(1'b1, 1'b1, 2, 1);
        check_all("dn.e0", 2, 1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            check_all($sformatf("dn.e%0d", k + 1), dn_cnt[k], 1, dn_tc[k], 0);
        end

        // reset held 2 cycles mid-RUN
        rst = 1'b1;
        cyc();
        check_all("rst.c1", 0, 0, 0, 0);
        cyc();
        check_all("rst.c2", 0, 0, 0, 0);
        rst = 1'b0;
        cyc();
        check_all("rst.after", 0, 0, 0, 0);

        // pause during RUN, up, limit=5, div=3
        start_seq(1'b0, 1'b0, 5, 3);
        for (int k = 1; k <= 5; k++) cyc();
        check_all("pz.pre", 1, 1, 0, 0);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_all($sformatf("pz.hold%0d", k), 1, 1, 0, 0);
        end
        pause = 1'b0;
        cyc();
        cyc();
        cyc();
        check_all("pz.before_step", 1, 1, 0, 0);
        cyc();
        check_all("pz.step", 2, 1, 0, 0);

        // start alone in RUN is ignored
        dir = 1'b1; limit = 4'd7; div = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        check_all("ign.e1", 2, 1, 0, 0);
        cyc();
        cyc();
        cyc();
        check_all("ign.step", 3, 1, 0, 0);

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check_all("coll", 0, 0, 0, 0);
        cyc();
        check_all("coll.idle", 0, 0, 0, 0);

        // limit=0, reload, div=0: tc every cycle
        start_seq(1'b0, 1'b1, 0, 0);
        check_all("l0r.e0", 0, 1, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check_all($sformatf("l0r.e%0d", k), 0, 1, 1, 0);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_all("l0r.stop", 0, 0, 0, 0);

        // limit=0 one-shot, div=2: DONE on first tick
        start_seq(1'b0, 1'b0, 0, 2);
        cyc();
        cyc();
        check_all("l0o.wait", 0, 1, 0, 0);
        cyc();
        check_all("l0o.term", 0, 0, 1, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_all("l0o.stop", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
